// File: rtl/tone_pkg.sv
// Shared types and constants for the tone/duration playback path.
// Note overflows are half-period counts at 50 MHz (50e6 / (2*f)).
package tone_pkg;

   localparam int W_DEF     = 28;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   localparam logic [W_DEF-1:0] REST_FREQ = '0;

   localparam logic [W_DEF-1:0] F3 = 28'd143172;
   localparam logic [W_DEF-1:0] G3 = 28'd127551;
   localparam logic [W_DEF-1:0] A3 = 28'd113636;
   localparam logic [W_DEF-1:0] B3 = 28'd101239;
   localparam logic [W_DEF-1:0] C4 = 28'd95556;
   localparam logic [W_DEF-1:0] D4 = 28'd85131;
   localparam logic [W_DEF-1:0] E4 = 28'd75843;
   localparam logic [W_DEF-1:0] F4 = 28'd71586;
   localparam logic [W_DEF-1:0] G4 = 28'd63776;

   // Beat lengths in clock cycles (120 bpm quarter note = 0.5 s).
   localparam logic [W_DEF-1:0] BEAT_E = 28'd12500000;
   localparam logic [W_DEF-1:0] BEAT_Q = 28'd25000000;
   localparam logic [W_DEF-1:0] BEAT_H = 28'd50000000;

endpackage

// File: rtl/tone_timer_ctrl_tone_divider.sv
// Square-wave generator: toggles tone every freq cycles while enabled.
// clr resets phase and output; mute forces the output low but keeps the count.
module tone_divider
   import tone_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic         mute,
   input  logic [W-1:0] freq,
   output logic         tone_out
);

   logic [W-1:0] tone_cnt_q, tone_cnt_d;
   logic         tone_q, tone_d;

   // Next phase count and toggle; a zero freq (rest) never toggles.
   always_comb begin
      tone_cnt_d = tone_cnt_q;
      tone_d     = tone_q;
      if (clr) begin
         tone_cnt_d = '0;
         tone_d     = 1'b0;
      end else if (mute) begin
         tone_d = 1'b0;
      end else if (en && freq != '0) begin
         if (tone_cnt_q == freq - W'(1)) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
         end else begin
            tone_cnt_d = tone_cnt_q + W'(1);
         end
      end
   end

   // Phase counter and toggle registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tone_cnt_q <= '0;
         tone_q     <= 1'b0;
      end else begin
         tone_cnt_q <= tone_cnt_d;
         tone_q     <= tone_d;
      end
   end

   assign tone_out = tone_q;

endmodule

// File: rtl/tone_timer_ctrl.sv
// Note playback controller: accepts one note at a time (half-period, duration),
// drives the speaker tone, times the note and pulses done in its last cycle.
// Optional build macro ARTIC_GAP_EN inserts a silent GAP_CYCLES gap after
// every note; without it back-to-back notes are seamless.
module tone_timer_ctrl
   import tone_pkg::*;
#(
   parameter int W          = W_DEF,
   parameter int GAP_CYCLES = 2500000,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             Clk_in,
   input  logic             Rst_n_in,
   input  logic             Play_in,
   input  logic             Stop_in,
   input  logic             Note_valid_in,
   output logic             Note_ready_out,
   input  logic [W-1:0]     Freq_in,
   input  logic [W-1:0]     Temp_in,
   output logic             Tone_out,
   output logic             Note_done_out,
   output logic             Busy_out,
   output logic [CNT_W-1:0] Note_cnt_out
);

`ifdef ARTIC_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_e           state_q, state_d;
   logic [W-1:0]     freq_q, freq_d;
   logic [W-1:0]     dur_q, dur_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             accept, done;
   logic             div_en, div_clr, div_mute;

   // Ready is combinational so a new note can load in the done cycle.
   assign Note_ready_out = !Stop_in && Play_in &&
                           (state_q == ST_IDLE ||
                            (!GAP_EN && state_q == ST_PLAY && dur_q == '0));
   assign accept = Note_valid_in && Note_ready_out;

   // Next-state, counters and divider controls; Stop overrides everything.
   always_comb begin
      state_d  = state_q;
      freq_d   = freq_q;
      dur_d    = dur_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      done     = 1'b0;
      div_en   = 1'b0;
      div_clr  = 1'b0;
      div_mute = 1'b0;
      if (Stop_in) begin
         state_d = ST_IDLE;
         dur_d   = '0;
         cnt_d   = '0;
         gap_d   = '0;
         div_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: ;
            ST_PLAY: begin
               if (!Play_in) begin
                  // This cycle still counts as sounding; freeze from next cycle.
                  state_d  = ST_PAUSE;
                  div_mute = 1'b1;
                  if (dur_q != '0) dur_d = dur_q - W'(1);
               end else if (dur_q == '0) begin
                  done    = 1'b1;
                  cnt_d   = cnt_q + CNT_W'(1);
                  div_clr = 1'b1;
                  if (GAP_EN) begin
                     state_d = ST_GAP;
                     gap_d   = GAP_W'(GAP_CYCLES - 1);
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  dur_d  = dur_q - W'(1);
                  div_en = 1'b1;
               end
            end
            ST_PAUSE: if (Play_in) state_d = ST_PLAY;
            ST_GAP: begin
               if (Play_in) begin
                  if (gap_q == '0) state_d = ST_IDLE;
                  else             gap_d   = gap_q - GAP_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
         if (accept) begin
            freq_d  = Freq_in;
            dur_d   = (Temp_in == '0) ? '0 : Temp_in - W'(1);
            div_clr = 1'b1;
            state_d = ST_PLAY;
         end
      end
   end

   // Controller state registers.
   always_ff @(posedge Clk_in) begin
      if (!Rst_n_in) begin
         state_q <= ST_IDLE;
         freq_q  <= '0;
         dur_q   <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         freq_q  <= freq_d;
         dur_q   <= dur_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
      end
   end

   tone_divider #(.W(W)) u_div (
      .clk      (Clk_in),
      .rst_n    (Rst_n_in),
      .en       (div_en),
      .clr      (div_clr),
      .mute     (div_mute),
      .freq     (freq_q),
      .tone_out (Tone_out)
   );

   assign Note_done_out = done;
   assign Busy_out      = (state_q != ST_IDLE);
   assign Note_cnt_out  = cnt_q;

endmodule
